// File: rtl/snake_dir_scheduler_pkg.sv
// Shared direction codes, game-flow states and turn helpers for the snake move scheduler.
package snake_dir_scheduler_pkg;

  localparam int DIR_W = 2;

  localparam logic [DIR_W-1:0] DIR_UP    = 2'b00;
  localparam logic [DIR_W-1:0] DIR_DOWN  = 2'b01;
  localparam logic [DIR_W-1:0] DIR_LEFT  = 2'b10;
  localparam logic [DIR_W-1:0] DIR_RIGHT = 2'b11;

  localparam logic [7:0] DROP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  // Opposite directions share the axis bit and differ in the sense bit.
  function automatic logic isOpposite(input logic [DIR_W-1:0] a, input logic [DIR_W-1:0] b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

  // A turn is only useful if it changes direction without reversing into the body.
  function automatic logic turnLegal(input logic [DIR_W-1:0] reqDir, input logic [DIR_W-1:0] refDir);
    return (reqDir != refDir) && !isOpposite(reqDir, refDir);
  endfunction

  // One-hot-ish vector ordered {up, down, left, right}; lowest code wins on multi-hot.
  function automatic logic [DIR_W-1:0] pickDir(input logic [3:0] hot);
    logic [DIR_W-1:0] d;
    if (hot[3])      d = DIR_UP;
    else if (hot[2]) d = DIR_DOWN;
    else if (hot[1]) d = DIR_LEFT;
    else             d = DIR_RIGHT;
    return d;
  endfunction

endpackage

// File: rtl/snake_dir_scheduler_dir_fifo.sv
// Small synchronous FIFO holding pending direction turns; a push into a full
// queue is still taken when a pop happens in the same cycle.
module snake_dir_scheduler_dir_fifo
  import snake_dir_scheduler_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [DIR_W-1:0]         i_din,
  output logic [DIR_W-1:0]         o_head,
  output logic [DIR_W-1:0]         o_tail,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DIR_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rdPtr;
  logic [AW-1:0]    r_wrPtr;
  logic [CW-1:0]    r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == CW'(DEPTH));
  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!o_full || w_doPop);
  assign o_head   = r_mem[r_rdPtr];
  assign o_tail   = r_mem[r_wrPtr - AW'(1)];
  assign o_count  = r_count;

  // Storage, pointers and occupancy; flush empties the queue without touching contents.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_mem[r_wrPtr] <= i_din;
        r_wrPtr        <= r_wrPtr + AW'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/snake_dir_scheduler.sv
// Snake move scheduler: arbitrates keyboard/button turn requests, filters
// illegal turns, queues them, and applies one per game tick under the
// IDLE/RUN/PAUSE game-flow FSM.
module snake_dir_scheduler
  import snake_dir_scheduler_pkg::*;
#(
  parameter int               TICK_CYCLES = 25_000_000,
  parameter int               QUEUE_DEPTH = 2,
  parameter logic [DIR_W-1:0] INIT_DIR    = 2'b11
) (
  input  logic             i_clk_crystal,
  input  logic             i_rst_global,
  input  logic             i_kb_up,
  input  logic             i_kb_down,
  input  logic             i_kb_left,
  input  logic             i_kb_right,
  input  logic             i_btn_up,
  input  logic             i_btn_down,
  input  logic             i_btn_left,
  input  logic             i_btn_right,
  input  logic             i_btn_start,
  input  logic             i_game_over,
  output logic [DIR_W-1:0] o_dir,
  output logic             o_step,
  output logic             o_running,
  output logic             o_paused,
  output logic [3:0]       o_q_level,
  output logic [7:0]       o_drop_cnt
);

  localparam int            TW        = $clog2(TICK_CYCLES);
  localparam int            CW        = $clog2(QUEUE_DEPTH + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  state_t           r_state;
  state_t           w_stateNext;
  logic [TW-1:0]    r_tickCnt;
  logic [DIR_W-1:0] r_dir;
  logic             r_step;
  logic [7:0]       r_dropCnt;

  logic             w_flush;
  logic             w_startRun;
  logic             w_stayRun;
  logic             w_tick;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [3:0]       w_kbHot;
  logic [3:0]       w_btnHot;
  logic [3:0]       w_reqHot;
  logic [DIR_W-1:0] w_reqDir;
  logic [DIR_W-1:0] w_refDir;
  logic             w_reqValid;

  logic [DIR_W-1:0] w_head;
  logic [DIR_W-1:0] w_tail;
  logic [CW-1:0]    w_count;
  logic             w_full;
  logic             w_empty;

  // Game-flow transitions; game_over outranks btn_start and is ignored in IDLE.
  always_comb begin
    w_stateNext = r_state;
    w_flush     = 1'b0;
    w_startRun  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_btn_start) begin
          w_stateNext = S_RUN;
          w_flush     = 1'b1;
          w_startRun  = 1'b1;
        end
      end
      S_RUN: begin
        if (i_game_over) begin
          w_stateNext = S_IDLE;
          w_flush     = 1'b1;
        end else if (i_btn_start) begin
          w_stateNext = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (i_game_over) begin
          w_stateNext = S_IDLE;
          w_flush     = 1'b1;
        end else if (i_btn_start) begin
          w_stateNext = S_RUN;
        end
      end
      default: begin
        w_stateNext = S_IDLE;
        w_flush     = 1'b1;
      end
    endcase
  end

  // Game-flow state register.
  always_ff @(posedge i_clk_crystal or posedge i_rst_global) begin
    if (i_rst_global) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // The tick only advances while RUN persists, so the cycle that pauses holds the count.
  assign w_stayRun = (r_state == S_RUN) && (w_stateNext == S_RUN);
  assign w_tick    = w_stayRun && (r_tickCnt == TICK_LAST);
  assign w_pop     = w_tick && !w_empty;

  // Keyboard wins over buttons; only one request is considered per cycle.
  assign w_kbHot    = {i_kb_up, i_kb_down, i_kb_left, i_kb_right};
  assign w_btnHot   = {i_btn_up, i_btn_down, i_btn_left, i_btn_right};
  assign w_reqHot   = (|w_kbHot) ? w_kbHot : w_btnHot;
  assign w_reqDir   = pickDir(w_reqHot);
  assign w_refDir   = w_empty ? r_dir : w_tail;
  assign w_reqValid = (|w_reqHot) && (r_state == S_RUN) && !i_game_over
                      && turnLegal(w_reqDir, w_refDir);
  assign w_push     = w_reqValid && (!w_full || w_pop);
  assign w_drop     = w_reqValid && w_full && !w_pop;

  snake_dir_scheduler_dir_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_dirFifo (
    .i_clk   (i_clk_crystal),
    .i_rst   (i_rst_global),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_din   (w_reqDir),
    .o_head  (w_head),
    .o_tail  (w_tail),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Move-step counter, restarted from zero whenever a new game begins.
  always_ff @(posedge i_clk_crystal or posedge i_rst_global) begin
    if (i_rst_global) begin
      r_tickCnt <= '0;
    end else if (w_startRun) begin
      r_tickCnt <= '0;
    end else if (w_stayRun) begin
      r_tickCnt <= (r_tickCnt == TICK_LAST) ? '0 : r_tickCnt + TW'(1);
    end
  end

  // Step pulse and direction update land together on the tick edge.
  always_ff @(posedge i_clk_crystal or posedge i_rst_global) begin
    if (i_rst_global) begin
      r_step <= 1'b0;
      r_dir  <= INIT_DIR;
    end else begin
      r_step <= w_tick;
      if (w_startRun) begin
        r_dir <= INIT_DIR;
      end else if (w_pop) begin
        r_dir <= w_head;
      end
    end
  end

  // Saturating count of legal turns lost to a full queue; cleared at game start.
  always_ff @(posedge i_clk_crystal or posedge i_rst_global) begin
    if (i_rst_global) begin
      r_dropCnt <= '0;
    end else if (w_startRun) begin
      r_dropCnt <= '0;
    end else if (w_drop && (r_dropCnt != DROP_MAX)) begin
      r_dropCnt <= r_dropCnt + 8'd1;
    end
  end

  assign o_dir      = r_dir;
  assign o_step     = r_step;
  assign o_running  = (r_state == S_RUN);
  assign o_paused   = (r_state == S_PAUSE);
  assign o_q_level  = 4'(w_count);
  assign o_drop_cnt = r_dropCnt;

endmodule
